// File: rtl/cardinal_pkg.sv
// Shared definitions for the Cardinal ID stage.
// Holds opcode and ALU function encodings, WW/PPP encodings, instruction
// field bit ranges (big-endian: bit 0 is the MSB), the decoded instruction
// class and helpers for opcode decode and PPP byte-lane selection.
package cardinal_pkg;

    // Instruction field ranges within if_instr[0:31]
    localparam int unsigned OPC_HI  = 0;
    localparam int unsigned OPC_LO  = 5;
    localparam int unsigned RD_HI   = 6;
    localparam int unsigned RD_LO   = 10;
    localparam int unsigned RA_HI   = 11;
    localparam int unsigned RA_LO   = 15;
    localparam int unsigned RB_HI   = 16;
    localparam int unsigned RB_LO   = 20;
    localparam int unsigned PPP_HI  = 21;
    localparam int unsigned PPP_LO  = 23;
    localparam int unsigned WW_HI   = 24;
    localparam int unsigned WW_LO   = 25;
    localparam int unsigned FUNC_HI = 26;
    localparam int unsigned FUNC_LO = 31;
    localparam int unsigned IMM_HI  = 16;
    localparam int unsigned IMM_LO  = 31;

    // Opcodes
    localparam logic [0:5] OP_RTYPE = 6'b101010;
    localparam logic [0:5] OP_VLD   = 6'b100000;
    localparam logic [0:5] OP_VSD   = 6'b100001;
    localparam logic [0:5] OP_VBEZ  = 6'b100010;
    localparam logic [0:5] OP_VBNEZ = 6'b100011;
    localparam logic [0:5] OP_VNOP  = 6'b111100;

    // ALU function codes carried in the func field of R-type instructions
    localparam logic [0:5] VAND   = 6'b000001;
    localparam logic [0:5] VOR    = 6'b000010;
    localparam logic [0:5] VXOR   = 6'b000011;
    localparam logic [0:5] VNOT   = 6'b000100;
    localparam logic [0:5] VMOV   = 6'b000101;
    localparam logic [0:5] VADD   = 6'b000110;
    localparam logic [0:5] VSUB   = 6'b000111;
    localparam logic [0:5] VMULEU = 6'b001000;
    localparam logic [0:5] VMULOU = 6'b001001;
    localparam logic [0:5] VSLL   = 6'b001010;
    localparam logic [0:5] VSRL   = 6'b001011;
    localparam logic [0:5] VSRA   = 6'b001100;
    localparam logic [0:5] VRTTH  = 6'b001101;
    localparam logic [0:5] VDIV   = 6'b001110;
    localparam logic [0:5] VMOD   = 6'b001111;
    localparam logic [0:5] VSQEU  = 6'b010000;
    localparam logic [0:5] VSQOU  = 6'b010001;
    localparam logic [0:5] VSQRT  = 6'b010010;

    // Word width
    localparam logic [0:1] WW_8  = 2'b00;
    localparam logic [0:1] WW_16 = 2'b01;
    localparam logic [0:1] WW_32 = 2'b10;
    localparam logic [0:1] WW_64 = 2'b11;

    // Participation field (byte-lane selection)
    localparam logic [0:2] PPP_ALL   = 3'b000;
    localparam logic [0:2] PPP_UPPER = 3'b001;
    localparam logic [0:2] PPP_LOWER = 3'b010;
    localparam logic [0:2] PPP_EVEN  = 3'b011;
    localparam logic [0:2] PPP_ODD   = 3'b100;

    typedef enum logic [2:0] {
        ClsNop,
        ClsRtype,
        ClsVld,
        ClsVsd,
        ClsVbez,
        ClsVbnez
    } instr_cls_e;

    function automatic instr_cls_e decode_class(input logic [0:5] opcode);
        instr_cls_e cls;
        case (opcode)
            OP_RTYPE: cls = ClsRtype;
            OP_VLD:   cls = ClsVld;
            OP_VSD:   cls = ClsVsd;
            OP_VBEZ:  cls = ClsVbez;
            OP_VBNEZ: cls = ClsVbnez;
            default:  cls = ClsNop;
        endcase
        return cls;
    endfunction

    // Byte idx counts from the MSB byte (byte 0 = bits [0:7]).
    function automatic logic byte_en(input logic [0:2] ppp, input int idx, input int nbytes);
        logic en;
        case (ppp)
            PPP_UPPER: en = (idx < nbytes / 2);
            PPP_LOWER: en = (idx >= nbytes / 2);
            PPP_EVEN:  en = ((idx % 2) == 0);
            PPP_ODD:   en = ((idx % 2) == 1);
            default:   en = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cardinal_regfile.sv
// Cardinal register file: NREG x DW, two combinational read ports, one
// write port with PPP byte-lane masking. R0 reads as zero and is never
// written. A read of the register being written this cycle returns the
// merged (post-write) value.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all registers)
//   ra_addr / ra_data   read port A
//   rb_addr / rb_data   read port B
//   we, waddr, wdata    write port
//   wppp                byte-lane participation for the write
module cardinal_regfile
    import cardinal_pkg::*;
#(
    parameter int unsigned DW   = 64,
    parameter int unsigned NREG = 32,
    localparam int unsigned RAW = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [0:RAW-1] ra_addr,
    output logic [0:DW-1]  ra_data,
    input  logic [0:RAW-1] rb_addr,
    output logic [0:DW-1]  rb_data,
    input  logic           we,
    input  logic [0:RAW-1] waddr,
    input  logic [0:DW-1]  wdata,
    input  logic [0:2]     wppp
);

    localparam int NBYTES = int'(DW / 8);

    logic [0:DW-1] mem [NREG];
    logic [0:DW-1] wmask;
    logic [0:DW-1] wmerged;
    logic          wr_en;

    assign wr_en = we && (waddr != '0);

    always_comb begin
        wmask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            wmask[i*8 +: 8] = {8{byte_en(wppp, i, NBYTES)}};
        end
    end

    // Unselected lanes keep their old contents.
    assign wmerged = (mem[waddr] & ~wmask) | (wdata & wmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NREG); r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wmerged;
        end
    end

    always_comb begin
        ra_data = mem[ra_addr];
        if (ra_addr == '0) begin
            ra_data = '0;
        end else if (wr_en && (ra_addr == waddr)) begin
            ra_data = wmerged;
        end
    end

    always_comb begin
        rb_data = mem[rb_addr];
        if (rb_addr == '0) begin
            rb_data = '0;
        end else if (wr_en && (rb_addr == waddr)) begin
            rb_data = wmerged;
        end
    end

endmodule

// File: rtl/cardinal_id_stage.sv
// Cardinal instruction-decode stage.
// Decodes if_instr, reads operands, resolves VBEZ/VBNEZ, detects RAW hazards
// against EX and MEM, and loads the ID/EX register feeding the vector ALU.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   if_valid, if_instr            instruction from IF
//   ex_stall                      downstream busy, hold ID/EX
//   wb_we/addr/data/ppp           writeback port into the register file
//   mem_rd_valid, mem_rd_addr     MEM-stage destination for hazard checks
//   id_stall                      hold IF and IF/ID
//   br_taken, br_target           combinational branch resolution
//   ex_*                          ID/EX register outputs
module cardinal_id_stage
    import cardinal_pkg::*;
#(
    parameter int unsigned DW   = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_valid,
    input  logic [0:31]   if_instr,
    input  logic          ex_stall,
    input  logic          wb_we,
    input  logic [0:4]    wb_addr,
    input  logic [0:DW-1] wb_data,
    input  logic [0:2]    wb_ppp,
    input  logic          mem_rd_valid,
    input  logic [0:4]    mem_rd_addr,
    output logic          id_stall,
    output logic          br_taken,
    output logic [0:AW-1] br_target,
    output logic          ex_valid,
    output logic [0:5]    ex_control,
    output logic [0:1]    ex_WW,
    output logic [0:2]    ex_ppp,
    output logic [0:DW-1] ex_rA_data,
    output logic [0:DW-1] ex_rB_data,
    output logic [0:4]    ex_rd_addr,
    output logic          ex_reg_we,
    output logic          ex_mem_rd,
    output logic          ex_mem_wr,
    output logic [0:AW-1] ex_imm
);

    // Instruction fields
    instr_cls_e    cls;
    logic [0:4]    rd, ra, rb, rb_sel;
    logic [0:2]    ppp;
    logic [0:1]    ww;
    logic [0:5]    func;
    logic [0:AW-1] imm;
    logic          is_branch, use_a, use_b;
    logic [0:DW-1] rdata_a, rdata_b;
    logic          hit_a, hit_b, hazard, accept;

    // ID/EX register
    logic          valid_q, valid_d;
    logic [0:5]    control_q, control_d;
    logic [0:1]    ww_q, ww_d;
    logic [0:2]    ppp_q, ppp_d;
    logic [0:DW-1] a_q, a_d;
    logic [0:DW-1] b_q, b_d;
    logic [0:4]    rd_q, rd_d;
    logic          we_q, we_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [0:AW-1] imm_q, imm_d;

    assign cls  = decode_class(if_instr[OPC_HI:OPC_LO]);
    assign rd   = if_instr[RD_HI:RD_LO];
    assign ra   = if_instr[RA_HI:RA_LO];
    assign rb   = if_instr[RB_HI:RB_LO];
    assign ppp  = if_instr[PPP_HI:PPP_LO];
    assign ww   = if_instr[WW_HI:WW_LO];
    assign func = if_instr[FUNC_HI:FUNC_LO];
    assign imm  = if_instr[IMM_HI:IMM_LO];

    assign is_branch = (cls == ClsVbez) || (cls == ClsVbnez);
    assign use_a     = (cls == ClsRtype);
    assign use_b     = (cls == ClsRtype) || (cls == ClsVsd) || is_branch;
    // VSD store data and branch operands come from the rD field via port B.
    assign rb_sel    = ((cls == ClsVsd) || is_branch) ? rd : rb;

    cardinal_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ra),
        .ra_data (rdata_a),
        .rb_addr (rb_sel),
        .rb_data (rdata_b),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .wppp    (wb_ppp)
    );

    // No forwarding: any in-flight producer in EX or MEM stalls the consumer.
    // WB producers are covered by register-file write-through.
    assign hit_a = (ra != '0) &&
                   ((valid_q && we_q && (ra == rd_q)) ||
                    (mem_rd_valid && (ra == mem_rd_addr)));
    assign hit_b = (rb_sel != '0) &&
                   ((valid_q && we_q && (rb_sel == rd_q)) ||
                    (mem_rd_valid && (rb_sel == mem_rd_addr)));

    assign hazard   = if_valid && ((use_a && hit_a) || (use_b && hit_b));
    assign id_stall = ex_stall || hazard;

    always_comb begin
        br_taken = 1'b0;
        if (if_valid && !id_stall) begin
            if (cls == ClsVbez) begin
                br_taken = (rdata_b == '0);
            end else if (cls == ClsVbnez) begin
                br_taken = (rdata_b != '0);
            end
        end
    end
    assign br_target = imm;

    // Branches resolve here and leave a bubble behind in EX.
    assign accept = if_valid && !hazard && !is_branch;

    always_comb begin
        valid_d   = 1'b0;
        control_d = '0;
        ww_d      = '0;
        ppp_d     = '0;
        a_d       = '0;
        b_d       = '0;
        rd_d      = '0;
        we_d      = 1'b0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        imm_d     = '0;
        if (ex_stall) begin
            valid_d   = valid_q;
            control_d = control_q;
            ww_d      = ww_q;
            ppp_d     = ppp_q;
            a_d       = a_q;
            b_d       = b_q;
            rd_d      = rd_q;
            we_d      = we_q;
            mem_rd_d  = mem_rd_q;
            mem_wr_d  = mem_wr_q;
            imm_d     = imm_q;
        end else if (accept) begin
            valid_d = 1'b1;
            ww_d    = ww;
            ppp_d   = ppp;
            imm_d   = imm;
            case (cls)
                ClsRtype: begin
                    control_d = func;
                    a_d       = rdata_a;
                    b_d       = rdata_b;
                    rd_d      = rd;
                    we_d      = 1'b1;
                end
                ClsVld: begin
                    rd_d     = rd;
                    we_d     = 1'b1;
                    mem_rd_d = 1'b1;
                end
                ClsVsd: begin
                    b_d      = rdata_b;
                    mem_wr_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            control_q <= '0;
            ww_q      <= '0;
            ppp_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            imm_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            control_q <= control_d;
            ww_q      <= ww_d;
            ppp_q     <= ppp_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            imm_q     <= imm_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_control = control_q;
    assign ex_WW      = ww_q;
    assign ex_ppp     = ppp_q;
    assign ex_rA_data = a_q;
    assign ex_rB_data = b_q;
    assign ex_rd_addr = rd_q;
    assign ex_reg_we  = we_q;
    assign ex_mem_rd  = mem_rd_q;
    assign ex_mem_wr  = mem_wr_q;
    assign ex_imm     = imm_q;

endmodule

// File: tb/tb_cardinal_id_stage.sv
// Self-checking bench for cardinal_id_stage.
module tb_cardinal_id_stage;
    import cardinal_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [0:31] if_instr;
    logic        ex_stall;
    logic        wb_we;
    logic [0:4]  wb_addr;
    logic [0:63] wb_data;
    logic [0:2]  wb_ppp;
    logic        mem_rd_valid;
    logic [0:4]  mem_rd_addr;
    logic        id_stall;
    logic        br_taken;
    logic [0:15] br_target;
    logic        ex_valid;
    logic [0:5]  ex_control;
    logic [0:1]  ex_WW;
    logic [0:2]  ex_ppp;
    logic [0:63] ex_rA_data;
    logic [0:63] ex_rB_data;
    logic [0:4]  ex_rd_addr;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [0:15] ex_imm;

    always #5 clk = ~clk;

    cardinal_id_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .ex_stall     (ex_stall),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_ppp       (wb_ppp),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_addr  (mem_rd_addr),
        .id_stall     (id_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .ex_valid     (ex_valid),
        .ex_control   (ex_control),
        .ex_WW        (ex_WW),
        .ex_ppp       (ex_ppp),
        .ex_rA_data   (ex_rA_data),
        .ex_rB_data   (ex_rB_data),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_we    (ex_reg_we),
        .ex_mem_rd    (ex_mem_rd),
        .ex_mem_wr    (ex_mem_wr),
        .ex_imm       (ex_imm)
    );

    typedef struct packed {
        logic        valid;
        logic [0:5]  ctl;
        logic [0:1]  ww;
        logic [0:2]  ppp;
        logic [0:63] a;
        logic [0:63] b;
        logic [0:4]  rd;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic [0:15] imm;
    } ex_t;

    typedef struct {
        string       name;
        logic [0:31] instr;
        ex_t         exp;
    } vec_t;

    ex_t  exp_q[$];
    vec_t vecs[9];
    int   checks   = 0;
    int   failures = 0;
    ex_t  bubble   = '0;
    ex_t  hold;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ex(input ex_t e, input string tag);
        chk({tag, ".ex_valid"},   64'(ex_valid),   64'(e.valid));
        chk({tag, ".ex_control"}, 64'(ex_control), 64'(e.ctl));
        chk({tag, ".ex_WW"},      64'(ex_WW),      64'(e.ww));
        chk({tag, ".ex_ppp"},     64'(ex_ppp),     64'(e.ppp));
        chk({tag, ".ex_rA_data"}, 64'(ex_rA_data), 64'(e.a));
        chk({tag, ".ex_rB_data"}, 64'(ex_rB_data), 64'(e.b));
        chk({tag, ".ex_rd_addr"}, 64'(ex_rd_addr), 64'(e.rd));
        chk({tag, ".ex_reg_we"},  64'(ex_reg_we),  64'(e.we));
        chk({tag, ".ex_mem_rd"},  64'(ex_mem_rd),  64'(e.mrd));
        chk({tag, ".ex_mem_wr"},  64'(ex_mem_wr),  64'(e.mwr));
        chk({tag, ".ex_imm"},     64'(ex_imm),     64'(e.imm));
    endtask

    task automatic pop_check(input string tag);
        ex_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got ex_valid=%0b expected a queued entry",
                     tag, ex_valid);
        end else begin
            e = exp_q.pop_front();
            check_ex(e, tag);
        end
    endtask

    // Inputs change on the falling edge; ID/EX is sampled 1 ns after the rising edge.
    task automatic run_cycle(input string tag);
        @(posedge clk);
        #1;
        pop_check(tag);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [0:31] instr);
        if_valid = v;
        if_instr = instr;
    endtask

    task automatic wb(input logic we, input logic [0:4] a, input logic [0:63] d,
                      input logic [0:2] p);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
        wb_ppp  = p;
    endtask

    function automatic logic [0:31] mk_r(input logic [0:5] func, input logic [0:4] rd,
                                         input logic [0:4] ra, input logic [0:4] rb,
                                         input logic [0:2] ppp, input logic [0:1] ww);
        return {OP_RTYPE, rd, ra, rb, ppp, ww, func};
    endfunction

    function automatic logic [0:31] mk_i(input logic [0:5] op, input logic [0:4] rd,
                                         input logic [0:15] imm);
        return {op, rd, 5'd0, imm};
    endfunction

    function automatic ex_t exp_instr(input logic [0:31] instr, input logic [0:5] ctl,
                                      input logic [0:63] a, input logic [0:63] b,
                                      input logic [0:4] rd, input logic we,
                                      input logic mrd, input logic mwr);
        ex_t e;
        logic [0:31] t;
        t       = instr;
        e.valid = 1'b1;
        e.ctl   = ctl;
        e.ww    = t[24:25];
        e.ppp   = t[21:23];
        e.imm   = t[16:31];
        e.a     = a;
        e.b     = b;
        e.rd    = rd;
        e.we    = we;
        e.mrd   = mrd;
        e.mwr   = mwr;
        return e;
    endfunction

    task automatic set_vec(input int i, input string name, input logic [0:31] instr,
                           input logic [0:5] ctl, input logic [0:63] a, input logic [0:63] b,
                           input logic [0:4] rd, input logic we, input logic mrd,
                           input logic mwr);
        vecs[i].name  = name;
        vecs[i].instr = instr;
        vecs[i].exp   = exp_instr(instr, ctl, a, b, rd, we, mrd, mwr);
    endtask

    initial begin
        logic [0:31] ins;

        rst_n = 1'b0;
        ex_stall = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_addr = '0;
        drive(1'b0, '0);
        wb(1'b0, '0, '0, '0);

        // Register contents after preload: R1=1111.., R3=0123.., R8=A5A5..,
        // R9=1, R10=FF00FF00FF00FF00, R11=00000000FFFFFFFF, R12=A500A500A500A500
        set_vec(0, "vadd", mk_r(VADD, 5'd5, 5'd3, 5'd0, 3'b000, 2'b01), 6'b000110,
                64'h0123456789ABCDEF, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        set_vec(1, "vxor", mk_r(VXOR, 5'd6, 5'd1, 5'd8, 3'b010, 2'b11), 6'b000011,
                64'h1111111111111111, 64'hA5A5A5A5A5A5A5A5, 5'd6, 1'b1, 1'b0, 1'b0);
        set_vec(2, "vand_ppp", mk_r(VAND, 5'd7, 5'd10, 5'd11, 3'b000, 2'b10), 6'b000001,
                64'hFF00FF00FF00FF00, 64'h00000000FFFFFFFF, 5'd7, 1'b1, 1'b0, 1'b0);
        set_vec(3, "vsd", mk_i(OP_VSD, 5'd3, 16'h1234), 6'b000000,
                64'h0, 64'h0123456789ABCDEF, 5'd0, 1'b0, 1'b0, 1'b1);
        set_vec(4, "vld", mk_i(OP_VLD, 5'd13, 16'h00AA), 6'b000000,
                64'h0, 64'h0, 5'd13, 1'b1, 1'b1, 1'b0);
        set_vec(5, "vsub_merge", mk_r(VSUB, 5'd17, 5'd12, 5'd9, 3'b000, 2'b00), 6'b000111,
                64'hA500A500A500A500, 64'h1, 5'd17, 1'b1, 1'b0, 1'b0);
        set_vec(6, "vor_r0", mk_r(VOR, 5'd18, 5'd0, 5'd9, 3'b000, 2'b11), 6'b000010,
                64'h0, 64'h1, 5'd18, 1'b1, 1'b0, 1'b0);
        set_vec(7, "vnop", mk_i(OP_VNOP, 5'd0, 16'h0000), 6'b000000,
                64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_vec(8, "bad_opcode", mk_i(6'b000111, 5'd9, 16'h5555), 6'b000000,
                64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        check_ex(bubble, "reset");
        chk("reset.id_stall", 64'(id_stall), 64'(0));
        chk("reset.br_taken", 64'(br_taken), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Preload through the writeback port
        wb(1'b1, 5'd3, 64'h0123456789ABCDEF, 3'b000); exp_q.push_back(bubble); run_cycle("wb_r3");
        wb(1'b1, 5'd1, 64'h1111111111111111, 3'b000); exp_q.push_back(bubble); run_cycle("wb_r1");
        wb(1'b1, 5'd8, 64'hA5A5A5A5A5A5A5A5, 3'b000); exp_q.push_back(bubble); run_cycle("wb_r8");
        wb(1'b1, 5'd9, 64'h0000000000000001, 3'b000); exp_q.push_back(bubble); run_cycle("wb_r9");
        wb(1'b1, 5'd10, '1, 3'b011);                  exp_q.push_back(bubble); run_cycle("wb_r10");
        wb(1'b1, 5'd11, '1, 3'b010);                  exp_q.push_back(bubble); run_cycle("wb_r11");
        wb(1'b1, 5'd12, 64'hA5A5A5A5A5A5A5A5, 3'b000); exp_q.push_back(bubble); run_cycle("wb_r12");
        wb(1'b1, 5'd12, 64'h0, 3'b100);               exp_q.push_back(bubble); run_cycle("wb_r12odd");
        wb(1'b1, 5'd0, 64'hDEADBEEFDEADBEEF, 3'b000); exp_q.push_back(bubble); run_cycle("wb_r0");
        wb(1'b0, '0, '0, '0);

        // Table-driven decode vectors (chosen to be hazard-free back to back)
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].instr);
            exp_q.push_back(vecs[i].exp);
            #1;
            chk({vecs[i].name, ".id_stall"}, 64'(id_stall), 64'(0));
            run_cycle(vecs[i].name);
        end
        drive(1'b0, '0); exp_q.push_back(bubble); run_cycle("idle0");

        // Write-through with PPP=001 in the same cycle as the read
        wb(1'b1, 5'd7, '1, 3'b001);
        ins = mk_r(VADD, 5'd14, 5'd7, 5'd0, 3'b000, 2'b01);
        drive(1'b1, ins);
        exp_q.push_back(exp_instr(ins, 6'b000110, 64'hFFFFFFFF00000000, 64'h0, 5'd14,
                                  1'b1, 1'b0, 1'b0));
        run_cycle("wt_ppp001");
        wb(1'b0, '0, '0, '0);
        ins = mk_r(VOR, 5'd15, 5'd7, 5'd7, 3'b000, 2'b11);
        drive(1'b1, ins);
        exp_q.push_back(exp_instr(ins, 6'b000010, 64'hFFFFFFFF00000000,
                                  64'hFFFFFFFF00000000, 5'd15, 1'b1, 1'b0, 1'b0));
        run_cycle("r7_stored");

        // Load-use: VLD R4 then VAND R6,R4,R1 stalls for EX then MEM match
        ins = mk_i(OP_VLD, 5'd4, 16'h0010);
        drive(1'b1, ins);
        exp_q.push_back(exp_instr(ins, 6'b000000, 64'h0, 64'h0, 5'd4, 1'b1, 1'b1, 1'b0));
        run_cycle("raw_vld");
        ins = mk_r(VAND, 5'd6, 5'd4, 5'd1, 3'b000, 2'b11);
        drive(1'b1, ins);
        exp_q.push_back(bubble);
        #1;
        chk("raw_ex.id_stall", 64'(id_stall), 64'(1));
        run_cycle("raw_ex");
        mem_rd_valid = 1'b1;
        mem_rd_addr  = 5'd4;
        exp_q.push_back(bubble);
        #1;
        chk("raw_mem.id_stall", 64'(id_stall), 64'(1));
        run_cycle("raw_mem");
        mem_rd_valid = 1'b0;
        mem_rd_addr  = '0;
        wb(1'b1, 5'd4, 64'hCAFEBABEDEADBEEF, 3'b000);
        exp_q.push_back(exp_instr(ins, 6'b000001, 64'hCAFEBABEDEADBEEF, 64'h1111111111111111,
                                  5'd6, 1'b1, 1'b0, 1'b0));
        #1;
        chk("raw_wb.id_stall", 64'(id_stall), 64'(0));
        run_cycle("raw_issue");
        wb(1'b0, '0, '0, '0);

        // Branches on R2
        drive(1'b1, mk_i(OP_VBEZ, 5'd2, 16'h0040));
        exp_q.push_back(bubble);
        #1;
        chk("vbez0.br_taken", 64'(br_taken), 64'(1));
        chk("vbez0.br_target", 64'(br_target), 64'(16'h0040));
        run_cycle("vbez0");
        drive(1'b0, '0);
        wb(1'b1, 5'd2, 64'h1, 3'b000);
        exp_q.push_back(bubble);
        run_cycle("wb_r2");
        wb(1'b0, '0, '0, '0);
        drive(1'b1, mk_i(OP_VBEZ, 5'd2, 16'h0040));
        exp_q.push_back(bubble);
        #1;
        chk("vbez1.br_taken", 64'(br_taken), 64'(0));
        run_cycle("vbez1");
        drive(1'b1, mk_i(OP_VBNEZ, 5'd2, 16'h0123));
        exp_q.push_back(bubble);
        #1;
        chk("vbnez1.br_taken", 64'(br_taken), 64'(1));
        chk("vbnez1.br_target", 64'(br_target), 64'(16'h0123));
        run_cycle("vbnez1");
        ins = mk_i(OP_VLD, 5'd2, 16'h0020);
        drive(1'b1, ins);
        exp_q.push_back(exp_instr(ins, 6'b000000, 64'h0, 64'h0, 5'd2, 1'b1, 1'b1, 1'b0));
        run_cycle("vld_r2");
        drive(1'b1, mk_i(OP_VBNEZ, 5'd2, 16'h0123));
        exp_q.push_back(bubble);
        #1;
        chk("br_hazard.id_stall", 64'(id_stall), 64'(1));
        chk("br_hazard.br_taken", 64'(br_taken), 64'(0));
        run_cycle("br_hazard");
        drive(1'b0, '0); exp_q.push_back(bubble); run_cycle("idle1");

        // ex_stall hold for three cycles, then VXOR enters exactly once
        ins  = mk_r(VADD, 5'd5, 5'd3, 5'd0, 3'b000, 2'b01);
        hold = exp_instr(ins, 6'b000110, 64'h0123456789ABCDEF, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        drive(1'b1, ins);
        exp_q.push_back(hold);
        run_cycle("pre_stall");
        ex_stall = 1'b1;
        ins = mk_r(VXOR, 5'd16, 5'd1, 5'd8, 3'b010, 2'b11);
        drive(1'b1, ins);
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(hold);
            #1;
            chk("ex_stall.id_stall", 64'(id_stall), 64'(1));
            run_cycle("ex_stall_hold");
        end
        ex_stall = 1'b0;
        exp_q.push_back(exp_instr(ins, 6'b000011, 64'h1111111111111111, 64'hA5A5A5A5A5A5A5A5,
                                  5'd16, 1'b1, 1'b0, 1'b0));
        #1;
        chk("release.id_stall", 64'(id_stall), 64'(0));
        run_cycle("release_vxor");
        drive(1'b0, '0); exp_q.push_back(bubble); run_cycle("vxor_once");

        // Asynchronous reset in the middle of an ex_stall
        ins = mk_i(OP_VLD, 5'd20, 16'h0BEE);
        drive(1'b1, ins);
        exp_q.push_back(exp_instr(ins, 6'b000000, 64'h0, 64'h0, 5'd20, 1'b1, 1'b1, 1'b0));
        run_cycle("pre_reset");
        ex_stall = 1'b1;
        drive(1'b1, mk_r(VADD, 5'd21, 5'd3, 5'd1, 3'b000, 2'b01));
        #2;
        rst_n    = 1'b0;
        ex_stall = 1'b0;
        drive(1'b0, '0);
        #1;
        check_ex(bubble, "async_reset");
        chk("async_reset.id_stall", 64'(id_stall), 64'(0));
        chk("async_reset.br_taken", 64'(br_taken), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wb(1'b1, 5'd0, '1, 3'b000);
        ins = mk_r(VADD, 5'd22, 5'd0, 5'd3, 3'b000, 2'b01);
        drive(1'b1, ins);
        exp_q.push_back(exp_instr(ins, 6'b000110, 64'h0, 64'h0, 5'd22, 1'b1, 1'b0, 1'b0));
        #1;
        chk("post_reset.id_stall", 64'(id_stall), 64'(0));
        run_cycle("post_reset_r0_wt");
        wb(1'b0, '0, '0, '0);
        ins = mk_r(VOR, 5'd23, 5'd0, 5'd0, 3'b000, 2'b11);
        drive(1'b1, ins);
        exp_q.push_back(exp_instr(ins, 6'b000010, 64'h0, 64'h0, 5'd23, 1'b1, 1'b0, 1'b0));
        run_cycle("post_reset_r0");
        drive(1'b0, '0); exp_q.push_back(bubble); run_cycle("idle2");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
